pattern_bit_serializer: RTL and testbench

PATTERN_BIT_SERIALIZER -- requirements
Module: pattern_bit_serializer

---
 rtl/ser_pkg.sv | 23 ++
 rtl/ser_shift_reg.sv | 32 +++
 rtl/pattern_bit_serializer.sv | 122 ++++++++++++
 tb/tb_pattern_bit_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the pattern bit serializer: FSM encoding and default word width.
// No logic; types and constants only.
// Optional parity stage is selected by macro SER_PARITY_EN (adds the PAR state).
package ser_pkg;

  // Default parallel word width used by the serializer top.
  localparam int SER_DATA_W = 8;

  // FSM encoding: IDLE=0, SHIFT=1, PAR=2 (PAR only present in the parity build).
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } ser_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } ser_state_e;
`endif

endpackage

// File: rtl/ser_shift_reg.sv
// Load/shift register feeding the serial output; direction set by MSB_FIRST.
// Latency: the loaded word's first bit is visible on bit_out the cycle after load.
// No backpressure: load has priority over shift, shift is a plain enable.
module ser_shift_reg #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              bit_out
);

  logic [DATA_W-1:0] sreg;

  // Capture a new word on load, otherwise move the next bit into the output position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      if (MSB_FIRST) sreg <= {sreg[DATA_W-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[DATA_W-1:1]};
    end
  end

  assign bit_out = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];

endmodule

// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial converter feeding a downstream pattern detector; optional even parity bit (macro SER_PARITY_EN).
// Latency: first serial bit appears one cycle after the transfer edge; words stream back to back.
// Backpressure: din_ready only in IDLE or on the last serial bit; din/din_valid ignored otherwise.
module pattern_bit_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W    = SER_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              out,
  output logic              out_valid,
  output logic              last
);

  localparam int            CW      = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

  ser_state_e    state;
  ser_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic          xfer;
  logic          shift_bit;
  logic          cnt_end;

  assign xfer    = din_valid & din_ready;
  assign cnt_end = (cnt == CNT_MAX);

  ser_shift_reg #(
    .DATA_W   (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (xfer),
    .shift  (state == ST_SHIFT),
    .din    (din),
    .bit_out(shift_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Bit counter: restarts on every accepted word, steps once per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= '0;
    end else if (state == ST_SHIFT) begin
      cnt <= cnt_end ? '0 : cnt + 1'b1;
    end
  end

`ifdef SER_PARITY_EN
  logic par_q;

  // Even parity of the accepted word, emitted after the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       par_q <= 1'b0;
    else if (xfer) par_q <= ^din;
  end
`endif

  // Next-state logic: a transfer on the final bit chains straight into the next word.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_end) begin
`ifdef SER_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = xfer ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        state_nxt = xfer ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state; IDLE drives zeros so the detector sees a quiet line.
  always_comb begin
    out       = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    case (state)
      ST_SHIFT: begin
        out       = shift_bit;
        out_valid = 1'b1;
`ifndef SER_PARITY_EN
        last      = cnt_end;
`endif
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        out       = par_q;
        out_valid = 1'b1;
        last      = 1'b1;
      end
`endif
      default: ;
    endcase
    din_ready = ~rst & ((state == ST_IDLE) | last);
  end

endmodule

// File: tb/tb_pattern_bit_serializer.sv
module tb_pattern_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic m_ready, m_out, m_ov, m_last;
  logic l_ready, l_out, l_ov, l_last;

  int vectors = 0;
  int errors  = 0;

  // Expected serial streams: front of queue is the bit on the line this cycle.
  bit qm[$];
  bit ql[$];

  // Downstream pattern detector (1001 / 1010) watching the MSB-first stream.
  bit          det_en = 1'b0;
  logic [3:0]  det_hist = '0;
  int          det_n = 0;
  logic [15:0] det_hits = '0;

  always #5 clk = ~clk;

  pattern_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .out(m_out), .out_valid(m_ov), .last(m_last)
  );

  pattern_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .out(l_out), .out_valid(l_ov), .last(l_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) qm.push_back(w[i]);
    for (int i = 0; i < W; i++) ql.push_back(w[i]);
`ifdef SER_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endfunction

  task automatic check_outputs();
    bit em, el;
    em = (qm.size() > 0) ? qm[0] : 1'b0;
    el = (ql.size() > 0) ? ql[0] : 1'b0;
    check("m_valid", m_ov,    qm.size() > 0);
    check("m_out",   m_out,   em);
    check("m_last",  m_last,  qm.size() == 1);
    check("m_ready", m_ready, qm.size() <= 1);
    check("l_valid", l_ov,    ql.size() > 0);
    check("l_out",   l_out,   el);
    check("l_last",  l_last,  ql.size() == 1);
    check("l_ready", l_ready, ql.size() <= 1);
    if (det_en && m_ov) begin
      det_hist = {det_hist[2:0], m_out};
      det_n++;
      if (det_n >= 4 && det_n <= 16 && (det_hist == 4'b1001 || det_hist == 4'b1010))
        det_hits[det_n-1] = 1'b1;
    end
  endtask

  // One clock: check at negedge, drive inputs, advance the model at posedge.
  task automatic cycle(input bit v, input logic [W-1:0] d, output bit xfer);
    bit rdy;
    @(negedge clk);
    check_outputs();
    din_valid = v;
    din       = d;
    rdy = (qm.size() <= 1);
    @(posedge clk);
    xfer = v && rdy;
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (xfer) push_word(d);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit x;
    int tries;
    x = 1'b0;
    tries = 0;
    while (!x && tries < 2 * W + 4) begin
      cycle(1'b1, w, x);
      tries++;
    end
    check("send_accepted", x, 1'b1);
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, x);
  endtask

  initial begin
    bit x;
    // Reset values while rst is held.
    #1;
    check("rst_m_valid", m_ov, 0);
    check("rst_m_out",   m_out, 0);
    check("rst_m_last",  m_last, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_l_ready", l_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, then quiet line.
    send(8'hA5);
    idle(10);

    // Held valid: two words back to back with no gap.
    send(8'h90);
    send(8'h0A);
    idle(12);

    // LSB-first instance: 1 then seven 0s.
    send(8'h01);
    idle(12);

    // Odd and even parity words (parity bit only in the parity build).
    send(8'h07);
    send(8'h03);
    idle(12);

    // Reset in the 4th bit of 8'hFF.
    send(8'hFF);
    idle(3);
    @(negedge clk);
    check_outputs();
    #1 rst = 1'b1;
    #1;
    check("midrst_m_valid", m_ov, 0);
    check("midrst_l_valid", l_ov, 0);
    check("midrst_m_ready", m_ready, 0);
    check("midrst_m_out",   m_out, 0);
    qm.delete();
    ql.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h0F);
    idle(12);

    // Detector hits on the 4th (1001) and 8th (1010) bits of 8'h9A.
    det_en   = 1'b1;
    det_hist = '0;
    det_n    = 0;
    det_hits = '0;
    send(8'h9A);
    idle(12);
    det_en = 1'b0;
    check("det_hits", det_hits, 16'h0088);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), x);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
